fp_div_sched: RTL and testbench

Two-port scheduler that shares one single-precision `fp_div` unit between two requesters. It arbitrates requests round-robin and keeps one operation in flight. It holds the operands and rounding mode stable for the whole operation, then returns the result and exception flags on a response channel tagged with the requester ID. A watchdog aborts operations whose `done` never arrives.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 49 ++++
 rtl/fp_div_sched.sv | 167 ++++++++++++++++
 tb/tb_fp_div_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the single-precision divider scheduler: rounding modes,
// canonical qNaN, flag-vector bit positions and the scheduler FSM encoding.
package fp_pkg;

    localparam logic [2:0] RmRne = 3'd0;
    localparam logic [2:0] RmRz  = 3'd1;
    localparam logic [2:0] RmRd  = 3'd2;
    localparam logic [2:0] RmRu  = 3'd3;
    localparam logic [2:0] RmRna = 3'd4;

    localparam logic [31:0] QNaN = 32'h7FC0_0000;

    // rsp_flags layout: {ov, un, inv, div_zero, inexact}
    localparam int unsigned FlagOv = 4;
    localparam int unsigned FlagUn = 3;
    localparam int unsigned FlagInv = 2;
    localparam int unsigned FlagDz = 1;
    localparam int unsigned FlagNx = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is granted; before any grant has been recorded requester 0 wins the tie.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    input  logic       upd_i
);

    logic last_q, last_d;
    logic seen_q, seen_d;
    logic tie_pick;

    always_comb begin
        // last_q is only meaningful once a grant has been recorded
        tie_pick = seen_q ? ~last_q : 1'b0;
        gnt_o    = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = tie_pick ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        seen_d = seen_q;
        if (upd_i) begin
            last_d = gnt_o[1];
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            last_q <= last_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// Shares one fp_div unit between two requesters: round-robin issue, one
// operation in flight, tagged response channel and a watchdog abort.
module fp_div_sched
    import fp_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned MIN_LAT = 3,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input  logic         clk_i,
    input  logic         rst_ni,

    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [W-1:0] req_a0_i,
    input  logic [W-1:0] req_b0_i,
    input  logic [W-1:0] req_a1_i,
    input  logic [W-1:0] req_b1_i,
    input  logic [2:0]   req_rm0_i,
    input  logic [2:0]   req_rm1_i,

    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [W-1:0] rsp_out_o,
    output logic [4:0]   rsp_flags_o,
    output logic         rsp_timeout_o,

    output logic [W-1:0] div_in1_o,
    output logic [W-1:0] div_in2_o,
    output logic [2:0]   div_round_m_o,
    output logic         div_act_o,
    input  logic [W-1:0] div_out_i,
    input  logic         div_ov_i,
    input  logic         div_un_i,
    input  logic         div_inv_i,
    input  logic         div_zero_i,
    input  logic         div_inexact_i,
    input  logic         div_done_i
);

    localparam logic [CW-1:0] MinLatC  = CW'(MIN_LAT);
    localparam logic [CW-1:0] TimeoutC = CW'(TIMEOUT);
    localparam logic [CW-1:0] CntMax   = {CW{1'b1}};

    state_e state_q, state_d;

    logic [1:0]   gnt;
    logic         arb_en;
    logic         accept;
    logic         busy;
    logic         done_ok;
    logic         tmo;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  op_a_q, op_b_q;
    logic [2:0]    op_rm_q;
    logic          op_id_q;
    logic [W-1:0]  rsp_out_q;
    logic [4:0]    rsp_flags_q, div_flags;
    logic          rsp_timeout_q;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .en_i   (arb_en),
        .gnt_o  (gnt),
        .upd_i  (accept)
    );

    assign accept  = |(req_valid_i & gnt);
    assign busy    = (state_q == StBusy);
    // Early done pulses are stale leftovers from the previous operation
    assign done_ok = div_done_i && (cnt_q >= MinLatC);
    assign tmo     = (cnt_q >= TimeoutC);

    always_comb begin
        div_flags          = 5'b00000;
        div_flags[FlagOv]  = div_ov_i;
        div_flags[FlagUn]  = div_un_i;
        div_flags[FlagInv] = div_inv_i;
        div_flags[FlagDz]  = div_zero_i;
        div_flags[FlagNx]  = div_inexact_i;
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; done is checked first so it wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StBusy;
            StBusy:  if (done_ok || tmo) state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        arb_en      = (state_q == StIdle);
        div_act_o   = (state_q == StBusy);
        rsp_valid_o = (state_q == StResp);
        req_ready_o = gnt;
    end

    always_comb begin
        cnt_d = '0;
        if (busy) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_rm_q <= '0;
            op_id_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                op_a_q  <= gnt[1] ? req_a1_i : req_a0_i;
                op_b_q  <= gnt[1] ? req_b1_i : req_b0_i;
                op_rm_q <= gnt[1] ? req_rm1_i : req_rm0_i;
                op_id_q <= gnt[1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_out_q     <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else if (busy && done_ok) begin
            rsp_out_q     <= div_out_i;
            rsp_flags_q   <= div_flags;
            rsp_timeout_q <= 1'b0;
        end else if (busy && tmo) begin
            rsp_out_q            <= W'(QNaN);
            rsp_flags_q          <= 5'b00000;
            rsp_flags_q[FlagInv] <= 1'b1;
            rsp_timeout_q        <= 1'b1;
        end
    end

    assign div_in1_o     = op_a_q;
    assign div_in2_o     = op_b_q;
    assign div_round_m_o = op_rm_q;

    assign rsp_id_o      = op_id_q;
    assign rsp_out_o     = rsp_out_q;
    assign rsp_flags_o   = rsp_flags_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_fp_div_sched.sv
// Directed bench for fp_div_sched with a behavioural divider whose latency,
// stale-done behaviour and results are set per scenario.
module tb_fp_div_sched;
    import fp_pkg::*;

    localparam int W = 32;
    localparam int MIN_LAT = 3;
    localparam int TIMEOUT = 64;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   rm0, rm1;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_timeout;
    logic [W-1:0] rsp_out;
    logic [4:0]   rsp_flags;
    logic [W-1:0] div_in1, div_in2, div_out;
    logic [2:0]   div_round_m;
    logic         div_act;
    logic         div_ov, div_un, div_inv, div_zero, div_inexact, div_done;

    int vectors = 0;
    int errors = 0;

    int lat = 5;
    bit stale_en = 1'b0;
    int dcnt = 0;

    fp_div_sched #(
        .W       (W),
        .MIN_LAT (MIN_LAT),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a0_i      (a0),
        .req_b0_i      (b0),
        .req_a1_i      (a1),
        .req_b1_i      (b1),
        .req_rm0_i     (rm0),
        .req_rm1_i     (rm1),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_out_o     (rsp_out),
        .rsp_flags_o   (rsp_flags),
        .rsp_timeout_o (rsp_timeout),
        .div_in1_o     (div_in1),
        .div_in2_o     (div_in2),
        .div_round_m_o (div_round_m),
        .div_act_o     (div_act),
        .div_out_i     (div_out),
        .div_ov_i      (div_ov),
        .div_un_i      (div_un),
        .div_inv_i     (div_inv),
        .div_zero_i    (div_zero),
        .div_inexact_i (div_inexact),
        .div_done_i    (div_done)
    );

    // Known quotients; returns {flags, quotient}
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            {32'h40C00000, 32'h40000000}: model = {5'b00000, 32'h40400000};
            {32'h3F800000, 32'h40000000}: model = {5'b00000, 32'h3F000000};
            {32'h41200000, 32'h40A00000}: model = {5'b00000, 32'h40000000};
            {32'h3F800000, 32'h00000000}: model = {5'b00010, 32'h7F800000};
            default:                      model = {5'b00001, 32'h12345678};
        endcase
    endfunction

    always @(posedge clk) dcnt <= div_act ? dcnt + 1 : 0;

    // Result is garbage until the modelled latency has elapsed
    assign {div_ov, div_un, div_inv, div_zero, div_inexact, div_out} =
        (div_act && dcnt >= lat) ? model(div_in1, div_in2) : {5'b11111, 32'hBAD0BAD0};
    assign div_done = (div_act && dcnt == lat) || (stale_en && (!div_act || dcnt < MIN_LAT));

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm);
        int n;
        n = 0;
        if (id == 0) begin a0 = a; b0 = b; rm0 = rm; end
        else begin a1 = a; b1 = b; rm1 = rm; end
        req_valid = (id == 0) ? 2'b01 : 2'b10;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 100);
        vectors++;
        if (req_ready[id] !== 1'b1) begin
            errors++;
            $display("FAIL issue_grant id=%0d: req_ready=%b required bit set", id, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
    endtask

    task automatic wait_rsp(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (req_ready !== 2'b00) rdy_seen = 1'b1;
        end while (rsp_valid !== 1'b1 && n < 200);
    endtask

    task automatic finish_rsp;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, div_act, rsp_timeout, rsp_id} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {rsp_valid, div_act, rsp_timeout, rsp_id});
        end
        vectors++;
        if ({rsp_out, rsp_flags, div_in1, div_in2, div_round_m} !== '0) begin
            errors++;
            $display("FAIL reset_data: out=%h flags=%b in1=%h in2=%h rm=%0d required all 0",
                     rsp_out, rsp_flags, div_in1, div_in2, div_round_m);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        int n;
        bit rs;
        lat = 5;
        a0 = 32'h3F800000; b0 = 32'h40000000; rm0 = RmRne;
        a1 = 32'h41200000; b1 = 32'h40A00000; rm1 = RmRne;
        req_valid = 2'b11;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL tie_first_grant: got %b required 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b10;
        wait_rsp(n, rs);
        vectors++;
        if (n !== 7 || rs !== 1'b0) begin
            errors++;
            $display("FAIL b2b_op0_timing: latency=%0d ready_seen=%b required 7/0", n, rs);
        end
        vectors++;
        if ({rsp_id, rsp_timeout, rsp_flags, rsp_out} !== {1'b0, 1'b0, 5'b0, 32'h3F000000}) begin
            errors++;
            $display("FAIL b2b_op0_rsp: id=%b to=%b fl=%b out=%h required 0/0/00000/3f000000",
                     rsp_id, rsp_timeout, rsp_flags, rsp_out);
        end
        finish_rsp();
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL tie_second_grant: ready=%b rsp_valid=%b required 10/0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_rsp(n, rs);
        vectors++;
        if (n !== 7 || rs !== 1'b0) begin
            errors++;
            $display("FAIL b2b_op1_timing: latency=%0d ready_seen=%b required 7/0", n, rs);
        end
        vectors++;
        if ({rsp_id, rsp_timeout, rsp_flags, rsp_out} !== {1'b1, 1'b0, 5'b0, 32'h40000000}) begin
            errors++;
            $display("FAIL b2b_op1_rsp: id=%b to=%b fl=%b out=%h required 1/0/00000/40000000",
                     rsp_id, rsp_timeout, rsp_flags, rsp_out);
        end
        finish_rsp();
    endtask

    task automatic test_basic;
        int n;
        bit rs;
        lat = 5;
        issue(0, 32'h40C00000, 32'h40000000, RmRne);
        @(negedge clk);
        vectors++;
        if ({div_act, div_in1, div_in2, div_round_m} !== {1'b1, 32'h40C00000, 32'h40000000, RmRne}) begin
            errors++;
            $display("FAIL basic_operands: act=%b in1=%h in2=%h rm=%0d required 1/40c00000/40000000/0",
                     div_act, div_in1, div_in2, div_round_m);
        end
        wait_rsp(n, rs);
        n++;
        vectors++;
        if (n !== 7 || rs !== 1'b0) begin
            errors++;
            $display("FAIL basic_timing: latency=%0d ready_seen=%b required 7/0", n, rs);
        end
        vectors++;
        if ({rsp_id, rsp_timeout, rsp_flags, rsp_out} !== {1'b0, 1'b0, 5'b0, 32'h40400000}) begin
            errors++;
            $display("FAIL basic_rsp: id=%b to=%b fl=%b out=%h required 0/0/00000/40400000",
                     rsp_id, rsp_timeout, rsp_flags, rsp_out);
        end
        finish_rsp();
    endtask

    task automatic test_div_zero;
        int n;
        bit rs;
        lat = 5;
        issue(0, 32'h3F800000, 32'h00000000, RmRz);
        wait_rsp(n, rs);
        vectors++;
        if ({rsp_flags, rsp_out, div_round_m} !== {5'b00010, 32'h7F800000, RmRz}) begin
            errors++;
            $display("FAIL div_zero_rsp: fl=%b out=%h rm=%0d required 00010/7f800000/1",
                     rsp_flags, rsp_out, div_round_m);
        end
        finish_rsp();
    endtask

    task automatic test_stale_done;
        int n;
        bit rs;
        lat = 4;
        stale_en = 1'b1;
        issue(1, 32'h41200000, 32'h40A00000, RmRu);
        wait_rsp(n, rs);
        stale_en = 1'b0;
        vectors++;
        if (n !== 6) begin
            errors++;
            $display("FAIL stale_done_timing: latency=%0d required 6", n);
        end
        vectors++;
        if ({rsp_id, rsp_timeout, rsp_flags, rsp_out} !== {1'b1, 1'b0, 5'b0, 32'h40000000}) begin
            errors++;
            $display("FAIL stale_done_rsp: id=%b to=%b fl=%b out=%h required 1/0/00000/40000000",
                     rsp_id, rsp_timeout, rsp_flags, rsp_out);
        end
        finish_rsp();
    endtask

    task automatic test_timeout;
        int n;
        bit rs;
        lat = 1000;
        issue(0, 32'h40C00000, 32'h40000000, RmRne);
        wait_rsp(n, rs);
        vectors++;
        if (n !== TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_timing: latency=%0d required %0d", n, TIMEOUT + 2);
        end
        vectors++;
        if ({rsp_id, rsp_timeout, rsp_flags, rsp_out} !== {1'b0, 1'b1, 5'b00100, 32'h7FC00000}) begin
            errors++;
            $display("FAIL timeout_rsp: id=%b to=%b fl=%b out=%h required 0/1/00100/7fc00000",
                     rsp_id, rsp_timeout, rsp_flags, rsp_out);
        end
        finish_rsp();
        lat = TIMEOUT;
        issue(1, 32'h40C00000, 32'h40000000, RmRd);
        wait_rsp(n, rs);
        vectors++;
        if (n !== TIMEOUT + 2) begin
            errors++;
            $display("FAIL done_vs_timeout_timing: latency=%0d required %0d", n, TIMEOUT + 2);
        end
        vectors++;
        if ({rsp_id, rsp_timeout, rsp_flags, rsp_out} !== {1'b1, 1'b0, 5'b0, 32'h40400000}) begin
            errors++;
            $display("FAIL done_vs_timeout_rsp: id=%b to=%b fl=%b out=%h required 1/0/00000/40400000",
                     rsp_id, rsp_timeout, rsp_flags, rsp_out);
        end
        finish_rsp();
        lat = 5;
    endtask

    task automatic test_backpressure;
        int n;
        bit rs;
        bit unstable;
        bit ready_bad;
        lat = 5;
        rsp_ready = 1'b0;
        issue(0, 32'h3F800000, 32'h40000000, RmRna);
        wait_rsp(n, rs);
        a1 = 32'h40C00000; b1 = 32'h40000000; rm1 = RmRne;
        req_valid = 2'b11;
        unstable = 1'b0;
        ready_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_id, rsp_timeout, rsp_flags, rsp_out} !==
                {1'b1, 1'b0, 1'b0, 5'b0, 32'h3F000000}) unstable = 1'b1;
            if (req_ready !== 2'b00 || div_in1 !== 32'h3F800000) ready_bad = 1'b1;
        end
        vectors++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: response changed, now id=%b out=%h required 0/3f000000",
                     rsp_id, rsp_out);
        end
        vectors++;
        if (ready_bad !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_stall: req_ready=%b in1=%h required 00/3f800000",
                     req_ready, div_in1);
        end
        rsp_ready = 1'b1;
        finish_rsp();
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b rsp_valid=%b required 10/0", req_ready, rsp_valid);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_busy;
        int n;
        bit rs;
        lat = 5;
        issue(0, 32'h40C00000, 32'h40000000, RmRu);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({div_act, rsp_valid, rsp_timeout, rsp_id, req_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: act=%b rv=%b to=%b id=%b rdy=%b required all 0",
                     div_act, rsp_valid, rsp_timeout, rsp_id, req_ready);
        end
        vectors++;
        if ({div_in1, div_in2, div_round_m, rsp_out, rsp_flags} !== '0) begin
            errors++;
            $display("FAIL midreset_data: in1=%h in2=%h rm=%0d out=%h fl=%b required all 0",
                     div_in1, div_in2, div_round_m, rsp_out, rsp_flags);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        a0 = 32'h3F800000; b0 = 32'h40000000; rm0 = RmRne;
        a1 = 32'h41200000; b1 = 32'h40A00000; rm1 = RmRne;
        req_valid = 2'b11;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midreset_tie: got %b required 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_rsp(n, rs);
        vectors++;
        if ({n == 7, rsp_id, rsp_out} !== {1'b1, 1'b0, 32'h3F000000}) begin
            errors++;
            $display("FAIL midreset_next_op: latency=%0d id=%b out=%h required 7/0/3f000000",
                     n, rsp_id, rsp_out);
        end
        finish_rsp();
    endtask

    initial begin
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rm0 = '0; rm1 = '0;
        test_reset();
        test_back_to_back();
        test_basic();
        test_div_zero();
        test_stale_done();
        test_timeout();
        test_backpressure();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
